mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 64-bit memory port between instruction fetch (IF, read-only) and the
//  MEM stage (load/store with byte enables from decode). One transaction outstanding at a time.
//  Sits between if_stage/mem_stage and the memory/bus bridge. MEM has priority; a starvation
//  counter forces an IF grant after MAX_D_CONSEC back-to-back MEM grants while IF waits.
// PARAMETERS
//  MAX_D_CONSEC  4   max consecutive MEM grants while IF pending (>=1)
//  ADDR_W        64  address width
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  if_req         in   1   IF request; held with if_addr stable until if_rsp_valid or if_kill
//  if_addr        in   64  IF fetch address
//  if_kill        in   1   pulse: discard the in-flight/pending IF response (branch redirect)
//  if_rsp_valid   out  1   1-cycle pulse, if_rsp_rdata valid
//  if_rsp_rdata   out  64  fetched data
//  d_req          in   1   MEM request; held with d_we/d_addr/d_wdata/d_be stable until d_rsp_valid
//  d_we           in   1   1=store, 0=load
//  d_addr         in   64  data address
//  d_wdata        in   64  store data
//  d_be           in   8   byte enable
//  d_rsp_valid    out  1   1-cycle pulse: load data valid / store acknowledged
//  d_rsp_rdata    out  64  load data (0 for stores)
//  m_req_valid    out  1   downstream request valid
//  m_req_ready    in   1   downstream accepts request when valid&ready
//  m_req_we/addr/wdata/be  out 1/64/64/8  registered copy of granted request (IF: we=0, be=8'hFF, wdata=0)
//  m_rsp_valid    in   1   downstream response (read data or write ack), 1 cycle
//  m_rsp_rdata    in   64  downstream read data
// BEHAVIOUR
//  Reset: state IDLE; m_req_valid, all m_req_* fields, if/d_rsp_valid, rsp_rdata, counter,
//   kill flag = 0. Reset mid-transaction abandons it; any m_rsp_valid arriving in IDLE is ignored.
//  States: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   IDLE: grant D if d_req && !(if_req && cnt==MAX_D_CONSEC); else grant I if if_req;
//    on grant: latch owner + request fields into m_req_*, m_req_valid<=1, go REQ.
//   REQ: hold m_req_* stable; on m_req_valid&m_req_ready: m_req_valid<=0, go WAIT.
//   WAIT: on m_rsp_valid: register rdata/valid to owner's rsp port, go RESP.
//   RESP: owner rsp_valid=1 this cycle only; requests ignored; go IDLE.
//  Latency (zero-wait memory, ready=1, rsp next cycle): req cycle 0, m_req_valid cycle 1,
//   m_rsp_valid cycle 2, rsp_valid cycle 3; next grant earliest cycle 4.
//  m_rsp_valid in REQ/same cycle as handshake: illegal downstream behaviour, ignored.
//  Counter cnt: on D grant with if_req=1, cnt<=min(cnt+1,MAX); on I grant or any IDLE cycle
//   with if_req=0, cnt<=0. Width $clog2(MAX_D_CONSEC+1).
//  Simultaneous if_req&d_req with cnt<MAX: D wins. cnt==MAX: I wins.
//  if_kill: if IF owns the transaction (REQ/WAIT/RESP-bound) set kill flag; m_req_valid is
//   NOT withdrawn; on response, if_rsp_valid suppressed; flag cleared on leaving RESP.
//   if_kill when IF does not own: no effect. if_kill has no effect on D transactions.
//  Stores: d_rsp_rdata=0 on write ack. Response rdata outputs hold last value otherwise.
// STRUCTURE
//  defines.v: ARB_IDLE/REQ/WAIT/RESP state encodings (2-bit), OWNER_IF/OWNER_D,
//   ZERO_WORD, REG_BUS. Single module; no sub-module needed (counter is inline).
// TESTING
//  1 lone if_req addr=0x8000_0000, ready=1, rdata=0x13 -> m_req_valid cyc1 we=0 be=FF; if_rsp_valid cyc3 rdata=0x13.
//  2 if_req&d_req same cycle (store addr=0x100, be=0x0F, wdata=0xDEAD) -> D served first, we=1; IF granted next, both rsp once.
//  3 d_req held continuously + if_req, MAX=4 -> exactly 4 D grants then 1 I grant; cnt back to 0.
//  4 m_req_ready low 5 cycles in REQ -> m_req_* stable throughout; one handshake; single rsp pulse.
//  5 IF in WAIT, if_kill pulse -> no if_rsp_valid; arbiter returns IDLE and grants pending d_req.
//  6 rst asserted in WAIT, m_rsp_valid arrives after reset -> all outputs 0, no rsp pulse, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> REQ -> WAIT -> RESP)
//   arb_owner_e : which requester owns the current transaction
//   ZERO_WORD / BE_ALL : constant fields used for IF reads and store acks
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W       = 64;
    localparam int unsigned ARB_DATA_W       = 64;
    localparam int unsigned ARB_BE_W         = 8;
    localparam int unsigned ARB_MAX_D_CONSEC = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } arb_owner_e;

    localparam logic [ARB_DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [ARB_BE_W-1:0]   BE_ALL    = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around the arbiter: IF fetch port, MEM load/store port and the
// single downstream memory port.
//   slave  : arbiter side (takes IF/MEM requests and memory responses)
//   master : environment side (fetch/mem stages and memory bridge)
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W
) ();

    // instruction fetch port
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_kill;
    logic                  if_rsp_valid;
    logic [ARB_DATA_W-1:0] if_rsp_rdata;

    // MEM stage port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [ARB_DATA_W-1:0] d_wdata;
    logic [ARB_BE_W-1:0]   d_be;
    logic                  d_rsp_valid;
    logic [ARB_DATA_W-1:0] d_rsp_rdata;

    // downstream memory port
    logic                  m_req_valid;
    logic                  m_req_ready;
    logic                  m_req_we;
    logic [ADDR_W-1:0]     m_req_addr;
    logic [ARB_DATA_W-1:0] m_req_wdata;
    logic [ARB_BE_W-1:0]   m_req_be;
    logic                  m_rsp_valid;
    logic [ARB_DATA_W-1:0] m_rsp_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata,
        output if_rsp_valid, if_rsp_rdata, d_rsp_valid, d_rsp_rdata,
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_be
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_req_ready, m_rsp_valid, m_rsp_rdata,
        input  if_rsp_valid, if_rsp_rdata, d_rsp_valid, d_rsp_rdata,
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_be
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (read-only) and the
// MEM stage (load/store). One transaction outstanding at a time. MEM has
// priority, but after MAX_D_CONSEC back-to-back MEM grants while IF waits the
// next grant goes to IF.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (IF port, MEM port, downstream port)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_CONSEC = ARB_MAX_D_CONSEC,
    parameter int unsigned ADDR_W       = ARB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_D_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_CONSEC);

    arb_state_e            state_q;
    arb_owner_e            owner_q;
    logic                  kill_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  m_valid_q;
    logic                  m_we_q;
    logic [ADDR_W-1:0]     m_addr_q;
    logic [ARB_DATA_W-1:0] m_wdata_q;
    logic [ARB_BE_W-1:0]   m_be_q;
    logic                  if_rsp_valid_q;
    logic [ARB_DATA_W-1:0] if_rdata_q;
    logic                  d_rsp_valid_q;
    logic [ARB_DATA_W-1:0] d_rdata_q;

    logic cnt_sat_c;
    logic grant_d_c;
    logic kill_hit_c;

    // MEM wins unless IF has been passed over MAX_D_CONSEC times in a row
    assign cnt_sat_c  = (cnt_q == CNT_MAX);
    assign grant_d_c  = bus.d_req && !(bus.if_req && cnt_sat_c);
    assign kill_hit_c = bus.if_kill && (owner_q == OWNER_IF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            owner_q        <= OWNER_IF;
            kill_q         <= 1'b0;
            cnt_q          <= '0;
            m_valid_q      <= 1'b0;
            m_we_q         <= 1'b0;
            m_addr_q       <= '0;
            m_wdata_q      <= '0;
            m_be_q         <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rdata_q     <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rdata_q      <= '0;
        end else begin
            // response strobes are single-cycle pulses
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;

            case (state_q)
                ARB_IDLE: begin
                    if (!bus.if_req) begin
                        cnt_q <= '0;
                    end
                    if (grant_d_c) begin
                        owner_q   <= OWNER_D;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_be_q    <= bus.d_be;
                        m_valid_q <= 1'b1;
                        state_q   <= ARB_REQ;
                        if (bus.if_req && !cnt_sat_c) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (bus.if_req) begin
                        owner_q   <= OWNER_IF;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        m_wdata_q <= ZERO_WORD;
                        m_be_q    <= BE_ALL;
                        m_valid_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ARB_REQ;
                    end
                end

                ARB_REQ: begin
                    // request stays posted even if IF is killed
                    if (kill_hit_c) begin
                        kill_q <= 1'b1;
                    end
                    if (bus.m_req_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ARB_WAIT;
                    end
                end

                ARB_WAIT: begin
                    if (kill_hit_c) begin
                        kill_q <= 1'b1;
                    end
                    if (bus.m_rsp_valid) begin
                        state_q <= ARB_RESP;
                        if (owner_q == OWNER_D) begin
                            d_rsp_valid_q <= 1'b1;
                            d_rdata_q     <= m_we_q ? ZERO_WORD : bus.m_rsp_rdata;
                        end else if (!(kill_q || bus.if_kill)) begin
                            if_rsp_valid_q <= 1'b1;
                            if_rdata_q     <= bus.m_rsp_rdata;
                        end
                    end
                end

                ARB_RESP: begin
                    kill_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end

                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.m_req_valid  = m_valid_q;
    assign bus.m_req_we     = m_we_q;
    assign bus.m_req_addr   = m_addr_q;
    assign bus.m_req_wdata  = m_wdata_q;
    assign bus.m_req_be     = m_be_q;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_rdata = if_rdata_q;
    assign bus.d_rsp_valid  = d_rsp_valid_q;
    assign bus.d_rsp_rdata  = d_rdata_q;

endmodule
